uart_param_core: RTL and testbench
==================================

UART_PARAM_CORE -- requirements
Module: uart_param_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sys_clk cycles per bit cell, even, legal 4..64.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit present.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits transmitted, legal 1..2.
REQ-006 SHALL have port sys_clk, input, 1, single clock; all logic on the rising edge.
REQ-007 SHALL have port sys_rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port tx_valid, input, 1, transmit request.
REQ-009 SHALL have port tx_data, input, DATA_BITS, byte to send.
REQ-010 SHALL have port tx_ready, output, 1, transmitter idle, can accept a request.
REQ-011 SHALL have port tx_done, output, 1, one-cycle pulse at frame end.
REQ-012 SHALL have port uart_tx, output, 1, serial line out, idle high.
REQ-013 SHALL have port uart_rx, input, 1, asynchronous serial line in.
REQ-014 SHALL have port rx_data, output, DATA_BITS, received word.
REQ-015 SHALL have port rx_valid, output, 1, rx_data/rx_*_err valid, held until consumed.
REQ-016 SHALL have port rx_ready, input, 1, consumer accepts rx_data.
REQ-017 SHALL have port rx_parity_err, output, 1, parity mismatch for the word held.
REQ-018 SHALL have port rx_frame_err, output, 1, first stop bit sampled low for the word held.
REQ-019 SHALL have port rx_overrun, output, 1, one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-020 SHALL accept a TX word when tx_valid & tx_ready on a clock edge; tx_data is captured then.
REQ-021 SHALL deassert tx_ready the cycle after acceptance; tx_valid without tx_ready is ignored.
REQ-022 SHALL use TX states IDLE, START, DATA, PARITY, STOP; START is entered the cycle after acceptance.
REQ-023 SHALL hold each bit on uart_tx for exactly OVERSAMPLE cycles: start 0, data LSB first, parity if PARITY_EN, then STOP_BITS stop bits of 1.
REQ-024 SHALL compute parity as XOR of data bits, inverted when PARITY_ODD=1.
REQ-025 SHALL pulse tx_done and reassert tx_ready in the cycle after the last stop cell; back-to-back requests then accepted without idle gap.
REQ-026 SHALL synchronise uart_rx through two flops before any use.
REQ-027 SHALL use RX states IDLE, START, DATA, PARITY, STOP; IDLE->START on a synchronised 1->0 transition.
REQ-028 SHALL resample start at OVERSAMPLE/2 cycles; if high (false start) return to IDLE without output.
REQ-029 SHALL sample each later bit at mid-cell, OVERSAMPLE cycles after the previous sample; only the first stop bit is checked.
REQ-030 SHALL, on the stop sample, load rx_data, rx_parity_err and rx_frame_err and assert rx_valid in the next cycle, even when errors are flagged.
REQ-031 SHALL clear rx_valid on rx_valid & rx_ready; if a new word lands the same cycle, the new word wins and rx_valid stays high without overrun.
REQ-032 SHALL, when a word lands with rx_valid high and rx_ready low, overwrite it and pulse rx_overrun.
REQ-033 SHALL return RX to IDLE after the stop sample; with stop low (framing error) a new start needs a fresh 1->0 transition.
REQ-034 SHALL size the cell counter to clog2(OVERSAMPLE) bits and the bit counter to clog2(DATA_BITS+1) bits with no wrap inside a frame.

Reset
REQ-035 SHALL, on sys_rst, asynchronously force: uart_tx=1, tx_ready=0, tx_done=0, rx_valid=0, rx_data=0, error outputs=0, rx_overrun=0, synchroniser flops=1, both FSMs IDLE.
REQ-036 SHALL assert tx_ready the first cycle after sys_rst deasserts; reset mid-frame aborts the frame with no tx_done or rx_valid.

Structure
REQ-037 SHALL place FSM state encodings and legal-range constants in shared package uart_param_pkg.
REQ-038 SHALL implement the receiver as sub-module uart_param_rx; TX logic is inline in uart_param_core.

Verification
REQ-039 SHALL check TX with defaults plus PARITY_EN=1, even, 0xA5: uart_tx = 0,1,0,1,0,0,1,0,1,0(parity),1; 176 cycles; tx_done at cycle 177.
REQ-040 SHALL check loopback uart_tx->uart_rx for words 0x00, 0xFF, 0x5A: rx_data matches; rx_valid set; both error flags 0.
REQ-041 SHALL check a frame with a flipped parity bit and one with stop=0: rx_parity_err=1, resp. rx_frame_err=1.
REQ-042 SHALL check a 4-cycle low glitch on uart_rx with OVERSAMPLE=16: no rx_valid; RX back in IDLE.
REQ-043 SHALL check two frames received with rx_ready=0: rx_overrun pulses once; rx_data = second word.
REQ-044 SHALL check sys_rst asserted mid-DATA: uart_tx=1 immediately; tx_ready=1 one cycle after release.

Source files
------------

// File: rtl/uart_param_pkg.sv
// Shared definitions for the parameterised UART: FSM state encoding and
// the legal parameter ranges checked at elaboration.
package uart_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 4;
    localparam int OVERSAMPLE_MAX = 64;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    function automatic bit cfg_legal(input int db, input int os, input int sb);
        return (db >= DATA_BITS_MIN) && (db <= DATA_BITS_MAX) &&
               (os >= OVERSAMPLE_MIN) && (os <= OVERSAMPLE_MAX) && (os % 2 == 0) &&
               (sb >= STOP_BITS_MIN) && (sb <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_param_rx.sv
// UART receiver: two-flop synchroniser, mid-cell sampling, word holding
// register with parity/framing flags and overrun pulse.
module uart_param_rx
    import uart_param_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    uart_state_e          r_state, w_state_nxt;
    logic [CW-1:0]        r_cell, w_cell_nxt;
    logic [BW-1:0]        r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par_bad, w_par_bad_nxt;
    logic                 w_rx_s, w_cell_end, w_land;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_perr, r_ferr, r_overrun;

    assign w_rx_s     = r_sync[1];
    assign w_cell_end = (r_cell == CELL_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_cell_nxt    = r_cell;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_par_bad_nxt = r_par_bad;
        w_land        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // only a genuine high-to-low edge starts a frame
                if (r_rx_prev && !w_rx_s) begin
                    w_state_nxt   = ST_START;
                    w_cell_nxt    = '0;
                    w_par_bad_nxt = 1'b0;
                end
            end
            ST_START: begin
                w_cell_nxt = r_cell + 1'b1;
                if (r_cell == HALF_LAST) begin
                    w_cell_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                w_cell_nxt = r_cell + 1'b1;
                if (w_cell_end) begin
                    w_cell_nxt  = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == BIT_LAST)
                        w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_cell_nxt = r_cell + 1'b1;
                if (w_cell_end) begin
                    w_cell_nxt    = '0;
                    w_par_bad_nxt = (^r_shift) ^ ODD_BIT ^ w_rx_s;
                    w_state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                w_cell_nxt = r_cell + 1'b1;
                if (w_cell_end) begin
                    w_cell_nxt  = '0;
                    w_land      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= ST_IDLE;
            r_cell    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx_s;
            r_state   <= w_state_nxt;
            r_cell    <= w_cell_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par_bad <= w_par_bad_nxt;
            r_overrun <= 1'b0;
            // a landing word always wins over a same-cycle consume
            if (w_land) begin
                r_data    <= r_shift;
                r_perr    <= r_par_bad;
                r_ferr    <= ~w_rx_s;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~i_ready;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
    assign o_overrun    = r_overrun;

endmodule

// File: rtl/uart_param_core.sv
// Parameterised UART core: inline transmitter FSM plus the uart_param_rx
// receiver, sharing one clock and an asynchronous active-high reset.
module uart_param_core
    import uart_param_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    if (!cfg_legal(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_bad_cfg
        $error("uart_param_core: illegal parameter combination");
    end

    uart_state_e          r_tx_state, w_tx_state_nxt;
    logic [CW-1:0]        r_tx_cell, w_tx_cell_nxt;
    logic [BW-1:0]        r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 r_tx_ready, w_tx_ready_nxt;
    logic                 r_tx_done, w_tx_done_nxt;
    logic                 r_uart_tx, w_uart_tx_nxt;
    logic                 w_tx_cell_end;

    assign w_tx_cell_end = (r_tx_cell == CELL_LAST);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cell_nxt  = r_tx_cell;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_tx_ready_nxt = r_tx_ready;
        w_tx_done_nxt  = 1'b0;
        w_uart_tx_nxt  = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_ready_nxt = 1'b1;
                if (tx_valid && r_tx_ready) begin
                    w_tx_state_nxt = ST_START;
                    w_tx_cell_nxt  = '0;
                    w_tx_shift_nxt = tx_data;
                    w_tx_par_nxt   = (^tx_data) ^ ODD_BIT;
                    w_tx_ready_nxt = 1'b0;
                end
            end
            ST_START: begin
                w_tx_cell_nxt = w_tx_cell_end ? '0 : r_tx_cell + 1'b1;
                if (w_tx_cell_end) begin
                    w_tx_state_nxt = ST_DATA;
                    w_tx_bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                w_tx_cell_nxt = w_tx_cell_end ? '0 : r_tx_cell + 1'b1;
                if (w_tx_cell_end) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    w_tx_bit_nxt   = r_tx_bit + 1'b1;
                    if (r_tx_bit == BIT_LAST) begin
                        w_tx_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        w_tx_bit_nxt   = '0;
                    end
                end
            end
            ST_PARITY: begin
                w_tx_cell_nxt = w_tx_cell_end ? '0 : r_tx_cell + 1'b1;
                if (w_tx_cell_end) begin
                    w_tx_state_nxt = ST_STOP;
                    w_tx_bit_nxt   = '0;
                end
            end
            ST_STOP: begin
                w_tx_cell_nxt = w_tx_cell_end ? '0 : r_tx_cell + 1'b1;
                if (w_tx_cell_end) begin
                    w_tx_bit_nxt = r_tx_bit + 1'b1;
                    if (r_tx_bit == STOP_LAST) begin
                        w_tx_state_nxt = ST_IDLE;
                        w_tx_done_nxt  = 1'b1;
                        w_tx_ready_nxt = 1'b1;
                    end
                end
            end
            default: w_tx_state_nxt = ST_IDLE;
        endcase
        // line is registered from the next state so it never glitches
        case (w_tx_state_nxt)
            ST_START:  w_uart_tx_nxt = 1'b0;
            ST_DATA:   w_uart_tx_nxt = w_tx_shift_nxt[0];
            ST_PARITY: w_uart_tx_nxt = w_tx_par_nxt;
            default:   w_uart_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cell  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_done  <= 1'b0;
            r_uart_tx  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cell  <= w_tx_cell_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_tx_done  <= w_tx_done_nxt;
            r_uart_tx  <= w_uart_tx_nxt;
        end
    end

    assign tx_ready = r_tx_ready;
    assign tx_done  = r_tx_done;
    assign uart_tx  = r_uart_tx;

    uart_param_rx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD)
    ) u_rx (
        .i_clk        (sys_clk),
        .i_rst        (sys_rst),
        .i_rx         (uart_rx),
        .i_ready      (rx_ready),
        .o_data       (rx_data),
        .o_valid      (rx_valid),
        .o_parity_err (rx_parity_err),
        .o_frame_err  (rx_frame_err),
        .o_overrun    (rx_overrun)
    );

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core (8 data bits, x16, even parity, 1 stop):
// exact TX waveform, loopback/error vectors from a table, glitch, overrun, reset abort.
module tb_uart_param_core;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_ready, tx_done, uart_tx;
    logic          uart_rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          rx_parity_err, rx_frame_err, rx_overrun;

    logic loop_sel = 1'b0;
    logic tb_rx    = 1'b1;
    assign uart_rx = loop_sel ? uart_tx : tb_rx;

    int n_chk  = 0;
    int n_fail = 0;
    int ovr_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (rx_overrun) ovr_cnt <= ovr_cnt + 1;

    uart_param_core #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .STOP_BITS  (1)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_done       (tx_done),
        .uart_tx       (uart_tx),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    typedef struct {
        logic          loop;
        logic [DB-1:0] data;
        logic          flip_par;
        logic          stop_val;
        logic [DB-1:0] exp_data;
        logic          exp_perr;
        logic          exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chkw(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic send_bit(input logic b);
        tb_rx = b;
        repeat (OS) tick();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic flip, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit((^d) ^ flip);
        send_bit(stop_v);
        send_bit(1'b1);
    endtask

    task automatic wait_rx(input string nm);
        for (int k = 0; k < 400 && !rx_valid; k++) tick();
        chkb(nm, rx_valid, 1'b1);
    endtask

    task automatic wait_tx_ready();
        for (int k = 0; k < 400 && !tx_ready; k++) tick();
        chkb("tx_ready_wait", tx_ready, 1'b1);
    endtask

    task automatic tx_send(input logic [DB-1:0] d);
        wait_tx_ready();
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chkb("rx_valid_cleared", rx_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_tx;
        int seen;
        int base;

        vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};

        // reset state
        #2 sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chkb("rst_uart_tx", uart_tx, 1'b1);
        chkb("rst_tx_ready", tx_ready, 1'b0);
        chkb("rst_tx_done", tx_done, 1'b0);
        chkb("rst_rx_valid", rx_valid, 1'b0);
        chkw("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chkb("rst_perr", rx_parity_err, 1'b0);
        chkb("rst_ferr", rx_frame_err, 1'b0);
        chkb("rst_overrun", rx_overrun, 1'b0);
        sys_rst = 1'b0;
        chkb("tx_ready_before_edge", tx_ready, 1'b0);
        tick();
        chkb("tx_ready_after_release", tx_ready, 1'b1);

        // exact TX frame for 0xA5 with even parity
        exp_tx = {1'b1, 1'b0, 8'hA5, 1'b0};
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        chkb("tx_ready_drop", tx_ready, 1'b0);
        for (int c = 1; c <= 176; c++) begin
            chkb("tx_line", uart_tx, exp_tx[(c - 1) / OS]);
            if (c == 176) chkb("tx_done_early", tx_done, 1'b0);
            tick();
        end
        chkb("tx_done_177", tx_done, 1'b1);
        chkb("tx_ready_177", tx_ready, 1'b1);
        chkb("tx_line_idle", uart_tx, 1'b1);
        tick();
        chkb("tx_done_pulse", tx_done, 1'b0);

        // loopback and error-injection vectors
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].loop) begin
                loop_sel = 1'b1;
                tx_send(vecs[v].data);
                wait_rx("vec_rx_valid");
            end else begin
                send_frame(vecs[v].data, vecs[v].flip_par, vecs[v].stop_val);
                chkb("vec_rx_valid", rx_valid, 1'b1);
            end
            chkw("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_data});
            chkb("vec_parity_err", rx_parity_err, vecs[v].exp_perr);
            chkb("vec_frame_err", rx_frame_err, vecs[v].exp_ferr);
            consume();
            if (vecs[v].loop) wait_tx_ready();
            loop_sel = 1'b0;
            repeat (4) tick();
        end

        // 4-cycle glitch must be rejected, then a real frame is still received
        tb_rx = 1'b0;
        repeat (4) tick();
        tb_rx = 1'b1;
        repeat (40) tick();
        chkb("glitch_no_valid", rx_valid, 1'b0);
        send_frame(8'h96, 1'b0, 1'b1);
        wait_rx("post_glitch_valid");
        chkw("post_glitch_data", {24'd0, rx_data}, 32'h96);
        consume();

        // two unconsumed words: one overrun pulse, second word held
        base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (4) tick();
        chkw("overrun_count", ovr_cnt - base, 32'd1);
        chkw("overrun_data", {24'd0, rx_data}, 32'h22);
        chkb("overrun_valid", rx_valid, 1'b1);
        consume();

        // reset in the middle of a looped-back DATA phase
        loop_sel = 1'b1;
        tx_send(8'h00);
        repeat (40) tick();
        chkb("mid_data_line_low", uart_tx, 1'b0);
        sys_rst = 1'b1;
        #1;
        chkb("abort_line_high", uart_tx, 1'b1);
        chkb("abort_tx_ready", tx_ready, 1'b0);
        repeat (3) tick();
        sys_rst = 1'b0;
        chkb("abort_ready_before_edge", tx_ready, 1'b0);
        tick();
        chkb("abort_ready_after_release", tx_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 250; k++) begin
            if (tx_done || rx_valid) seen++;
            tick();
        end
        chkw("abort_no_done_no_valid", seen, 32'd0);
        loop_sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
